// File: rtl/dmem_bridge.sv
// Data-memory bridge: decodes core data accesses to on-chip RAM or handshaked I/O
// channels, sequences them and stalls the core until each access completes.
module dmem_bridge #(
  parameter int          DATA_W  = 32,
  parameter int          RAM_AW  = 11,
  parameter int          NUM_IO  = 4,
  parameter logic [31:0] IO_BASE = 32'h0001_0000,
  parameter int          TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ack,
  output logic                     cpu_stall,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic                     ram_we,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic [NUM_IO-1:0]        io_req,
  output logic                     io_we,
  output logic [7:0]               io_addr,
  output logic [DATA_W-1:0]        io_wdata,
  input  logic [NUM_IO-1:0]        io_ack,
  input  logic [NUM_IO*DATA_W-1:0] io_rdata,
  input  logic                     err_clr,
  output logic [1:0]               err,
  output logic [2:0]               state_dbg
);

  // Handshake: cpu_req is held with stable fields until the single-cycle cpu_ack;
  // io_req[k] is held until io_ack[k] is seen or the wait times out.
  typedef enum logic [2:0] {S_IDLE, S_RAM_ACC, S_RAM_RD, S_IO_WAIT, S_RESP} state_t;

  localparam int          CNT_W     = $clog2(TIMEOUT);
  localparam logic [32:0] RAM_LIMIT = 33'(4) << RAM_AW;
  localparam logic [31:0] IO_SPAN   = 32'(NUM_IO * 256);

  state_t              state, state_n;
  logic                we_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic [7:0]          io_addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [2:0]          ch_q;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          err_q;
  logic [1:0]          err_set;

  logic [31:0]         io_off;
  logic                ram_hit, io_hit, cnt_last;
  logic [NUM_IO-1:0]   ch_onehot;
  logic                ack_sel;
  logic [DATA_W-1:0]   rdata_sel;

  assign io_off   = cpu_addr - IO_BASE;
  assign ram_hit  = {1'b0, cpu_addr} < RAM_LIMIT;
  assign io_hit   = (cpu_addr >= IO_BASE) && (io_off < IO_SPAN);
  assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    ch_onehot = '0;
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      if (ch_q == 3'(k)) begin
        ch_onehot[k] = 1'b1;
        ack_sel      = io_ack[k];
        rdata_sel    = io_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    ram_we    = 1'b0;
    io_req    = '0;
    io_we     = 1'b0;
    err_set   = 2'b00;
    case (state)
      S_IDLE: begin
        if (cpu_req) begin
          if (ram_hit)     state_n = S_RAM_ACC;
          else if (io_hit) state_n = S_IO_WAIT;
          else begin
            state_n    = S_RESP;
            err_set[0] = 1'b1;
          end
        end
      end
      S_RAM_ACC: begin
        ram_we = we_q;
        if (we_q) begin
          cpu_ack = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_RAM_RD;
        end
      end
      S_RAM_RD: begin
        cpu_rdata = ram_rdata;
        cpu_ack   = 1'b1;
        state_n   = S_IDLE;
      end
      S_IO_WAIT: begin
        io_req = ch_onehot;
        io_we  = we_q;
        if (ack_sel) state_n = S_RESP;
        else if (cnt_last) begin
          state_n    = S_RESP;
          err_set[1] = 1'b1;
        end
      end
      S_RESP: begin
        cpu_rdata = rdata_q;
        cpu_ack   = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      ram_addr_q <= '0;
      io_addr_q  <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ch_q       <= '0;
      cnt        <= '0;
      err_q      <= 2'b00;
    end else begin
      // A new error event outranks a simultaneous clear.
      err_q <= (err_q & ~{2{err_clr}}) | err_set;
      if (state == S_IDLE && cpu_req) begin
        we_q       <= cpu_we;
        ram_addr_q <= cpu_addr[RAM_AW+1:2];
        io_addr_q  <= cpu_addr[7:0];
        wdata_q    <= cpu_wdata;
        ch_q       <= io_off[10:8];
        cnt        <= '0;
        rdata_q    <= '0;
      end else if (state == S_IO_WAIT) begin
        cnt <= cnt + 1'b1;
        if (ack_sel)       rdata_q <= we_q ? '0 : rdata_sel;
        else if (cnt_last) rdata_q <= '1;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = wdata_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = wdata_q;
  assign err       = err_q;
  assign state_dbg = state;

endmodule
